uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, clk cycles per bit (9600 baud at 100 MHz); legal range 16..16383.
REQ-002 Parameter HALF_BIT, default CLKS_PER_BIT/2 (integer divide), clk cycles from start-bit detection to start-bit mid-sample.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low.
REQ-005 rxd  input  1  asynchronous serial line; idles high; frame format 8N1, LSB first.
REQ-006 ack  input  1  consumer acknowledge; clears valid, overrun and frame_err.
REQ-007 data  output  8  last correctly framed received byte.
REQ-008 valid  output  1  high while data holds an unconsumed byte.
REQ-009 frame_err  output  1  sticky; set when a stop bit is sampled low.
REQ-010 overrun  output  1  sticky; set when a byte completes while valid=1 and ack=0.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer; rxd_s is the second flop and is the only internal use of rxd.
REQ-013 A 14-bit bit-timer SHALL count clk cycles; it clears on every state transition and at every sample point.
REQ-014 IDLE: rxd_s=0 -> START with timer=0; else stay.
REQ-015 START: at timer=HALF_BIT-1, sample rxd_s. If 0 -> DATA with bit index 0. If 1 -> IDLE (glitch rejected; no flags change).
REQ-016 DATA: at timer=CLKS_PER_BIT-1, shift rxd_s into the MSB of an 8-bit shift register (shift right) and increment bit index. After the 8th sample -> STOP.
REQ-017 STOP: at timer=CLKS_PER_BIT-1, sample rxd_s.
- If 1: data <= shift register; valid <= 1; -> IDLE.
- If 0: frame_err <= 1; data and valid unchanged; -> BREAK.
REQ-018 BREAK: stay until rxd_s=1, then -> IDLE. This state prevents a low line from being taken as a new start bit.
REQ-019 All sample points SHALL be mid-bit: HALF_BIT cycles after detection, then every CLKS_PER_BIT cycles.
REQ-020 Latency: valid SHALL rise on the clock edge of the stop sample, HALF_BIT+9*CLKS_PER_BIT cycles after the edge where IDLE first saw rxd_s=0.
REQ-021 ack=1 on a cycle with no byte completing SHALL clear valid, overrun and frame_err on that edge, whether or not valid=1.
REQ-022 Byte completing with valid=1 and ack=0: data is overwritten with the new byte, valid stays 1, overrun <= 1.
REQ-023 Byte completing with ack=1 in the same cycle: the new byte is loaded, valid=1, overrun is not set, and overrun and frame_err are cleared.
REQ-024 Framing error with ack=1 in the same cycle: frame_err=1 (the set wins); valid and overrun are cleared.
REQ-025 The receiver SHALL never stall: reception proceeds regardless of valid or ack.
REQ-026 A bit index of 8 or more outside STOP, or an undefined state encoding, SHALL force IDLE on the next edge.

Reset
REQ-027 rst_n=0 on a rising edge SHALL set: state IDLE, timer 0, bit index 0, shift register 0x00, both synchronizer flops 1.
REQ-028 rst_n=0 on a rising edge SHALL set outputs: data=0x00, valid=0, frame_err=0, overrun=0, busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame without any flag update. The first frame after rst_n=1 SHALL be received normally.

Verification (CLKS_PER_BIT=16, HALF_BIT=8)
REQ-030 Reset: rst_n=0 for 5 cycles while rxd toggles -> all outputs 0, busy=0 throughout.
REQ-031 Normal frame: send 0x39 8N1 -> data=0x39, valid=1, frame_err=0, overrun=0 at REQ-020 timing; pulse ack -> valid=0 on the next edge.
REQ-032 Glitch: rxd low for 4 cycles, then high -> no valid; busy returns to 0 by 8 cycles after detection; a following 0x55 is received correctly.
REQ-033 Framing error: send 0xA5 with the stop bit low, hold rxd low 40 cycles, then high -> frame_err=1, valid=0, data unchanged, busy held through the low period; a next frame 0x5A gives data=0x5A, valid=1, frame_err=1 until ack.
REQ-034 Overrun: send 0x01 then 0x02 back-to-back with no ack -> data=0x02, valid=1, overrun=1; ack -> valid=0 and overrun=0.
REQ-035 Ack collision and mid-frame reset: ack=1 on the completion edge of 0x7E -> valid=1, overrun=0. Then assert rst_n=0 during data bit 3 of 0xC3 -> outputs return to reset values; the next frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling driven by a bit timer,
// and sticky valid/overrun/frame_err flags cleared by a consumer acknowledge.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] HALF_LAST = 14'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] timer_q, timer_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        rxd_meta_q, rxd_s_q;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        sample_pt;
  logic        stop_sample;
  logic        byte_done;
  logic        frame_bad;

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rxd_meta_q  <= rxd;
      rxd_s_q     <= rxd_meta_q;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    sample_pt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (timer_q == HALF_LAST) begin
          sample_pt = 1'b1;
          if (!rxd_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          sample_pt = 1'b1;
          shift_d   = {rxd_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          sample_pt = 1'b1;
          bit_idx_d = '0;
          state_d   = rxd_s_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        bit_idx_d = '0;
      end
    endcase
    // An out-of-range bit index can only come from corruption; recover to IDLE
    if (state_q != S_STOP && bit_idx_q >= 4'd8) begin
      state_d   = S_IDLE;
      bit_idx_d = '0;
      sample_pt = 1'b0;
    end
    timer_d = (state_d != state_q || sample_pt) ? 14'd0 : timer_q + 14'd1;
  end

  // Output logic: consumer flags and busy
  always_comb begin
    stop_sample = (state_q == S_STOP) && (timer_q == BIT_LAST);
    byte_done   = stop_sample && rxd_s_q;
    frame_bad   = stop_sample && !rxd_s_q;
    data_d      = byte_done ? shift_q : data_q;

    valid_d = valid_q;
    if (byte_done)  valid_d = 1'b1;
    else if (ack)   valid_d = 1'b0;

    overrun_d = overrun_q;
    if (ack)                   overrun_d = 1'b0;
    else if (byte_done && valid_q) overrun_d = 1'b1;

    // A framing error in the same cycle as ack still leaves the flag set
    frame_err_d = frame_err_q;
    if (frame_bad) frame_err_d = 1'b1;
    else if (ack)  frame_err_d = 1'b0;

    busy = (state_q != S_IDLE);
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
